clock_set_controller: RTL

- Button-driven set-mode sequencer for the millennium clock. Replaces the SW-based set_mode/field_sel scheme.
- Steps through the six editable fields (sec, min, hour, day, month, year) on a mode key.
- Issues per-field one-cycle inc/dec strobes, with auto-repeat while a key is held.
- Produces blink blank masks and the display page select.
- Falls back to run mode after an inactivity timeout.
- Sits between the debounced button pulses and the counter chain's inc_manual/dec_manual inputs.

---
 rtl/clock_pkg.sv | 49 ++++
 rtl/clock_set_controller_key_autorepeat.sv | 38 +++
 rtl/clock_set_controller.sv | 126 ++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock set-mode controller: field codes,
// per-field bit positions and the FSM state type.
package clock_pkg;

    // Field codes as seen on the controller's field output
    localparam logic [2:0] FLD_IDLE  = 3'd0;
    localparam logic [2:0] FLD_SEC   = 3'd1;
    localparam logic [2:0] FLD_MIN   = 3'd2;
    localparam logic [2:0] FLD_HOUR  = 3'd3;
    localparam logic [2:0] FLD_DAY   = 3'd4;
    localparam logic [2:0] FLD_MONTH = 3'd5;
    localparam logic [2:0] FLD_YEAR  = 3'd6;

    // Bit positions inside the 6-bit strobe and blank vectors
    localparam int FB_SEC   = 0;
    localparam int FB_MIN   = 1;
    localparam int FB_HOUR  = 2;
    localparam int FB_DAY   = 3;
    localparam int FB_MONTH = 4;
    localparam int FB_YEAR  = 5;

    // Set-mode states; the encoding matches the field codes directly
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEC   = 3'd1,
        ST_MIN   = 3'd2,
        ST_HOUR  = 3'd3,
        ST_DAY   = 3'd4,
        ST_MONTH = 3'd5,
        ST_YEAR  = 3'd6
    } set_state_t;

    // One-hot select of the edited field; all zero when idle
    function automatic logic [5:0] field_onehot(input set_state_t st);
        logic [5:0] oh;
        oh = '0;
        case (st)
            ST_SEC:   oh[FB_SEC]   = 1'b1;
            ST_MIN:   oh[FB_MIN]   = 1'b1;
            ST_HOUR:  oh[FB_HOUR]  = 1'b1;
            ST_DAY:   oh[FB_DAY]   = 1'b1;
            ST_MONTH: oh[FB_MONTH] = 1'b1;
            ST_YEAR:  oh[FB_YEAR]  = 1'b1;
            default:  oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/clock_set_controller_key_autorepeat.sv
// Hold-to-repeat timer for one key direction. While enabled it counts
// sample ticks; the first repeat fires after the delay, later repeats
// every period. The press itself never comes from here.
module key_autorepeat #(
    parameter int DELAY_TICKS  = 500,
    parameter int PERIOD_TICKS = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_ce,
    input  logic enable,
    input  logic clear,
    output logic rpt_pulse
);
    import clock_pkg::*;

    localparam int CW = $clog2(DELAY_TICKS) + 1;
    localparam logic [CW-1:0] FIRE_AT = CW'(DELAY_TICKS - 1);
    localparam logic [CW-1:0] RELOAD  = CW'(DELAY_TICKS - PERIOD_TICKS);

    logic [CW-1:0] count;

    // Fire on the tick that would bring the count up to the delay value
    assign rpt_pulse = enable && !clear && sample_ce && (count == FIRE_AT);

    // Hold counter: restarts whenever the key situation changes, and jumps
    // back by one period after each repeat so later repeats come faster
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!enable || clear) begin
            count <= '0;
        end else if (sample_ce) begin
            count <= (count == FIRE_AT) ? RELOAD : count + CW'(1);
        end
    end

endmodule

// File: rtl/clock_set_controller.sv
// Button-driven set-mode sequencer: walks the editable fields on the mode
// key, issues per-field inc/dec strobes with auto-repeat, drives the blink
// blanking and the time/date page select, and drops back to run mode
// after a period without key activity.
module clock_set_controller
    import clock_pkg::*;
#(
    parameter int CE_HZ            = 1000,
    parameter int REPEAT_DELAY_MS  = 500,
    parameter int REPEAT_PERIOD_MS = 100,
    parameter int TIMEOUT_S        = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_ce,
    input  logic       tick_1hz,
    input  logic       blink_2hz,
    input  logic       mode_p,
    input  logic       view_p,
    input  logic       up_p,
    input  logic       down_p,
    input  logic       up_held,
    input  logic       down_held,
    output logic       set_active,
    output logic [2:0] field,
    output logic [5:0] inc_stb,
    output logic [5:0] dec_stb,
    output logic [5:0] blank_mask,
    output logic       display_sel
);

    localparam int DELAY_TICKS  = REPEAT_DELAY_MS * CE_HZ / 1000;
    localparam int PERIOD_TICKS = REPEAT_PERIOD_MS * CE_HZ / 1000;
    localparam int TW           = $clog2(TIMEOUT_S) + 1;

    set_state_t    state;
    logic [TW-1:0] tout_count;
    logic          idle;
    logic          timeout_hit;
    logic          both_press;
    logic          rpt_clear;
    logic          rpt_up;
    logic          rpt_dn;
    logic          strobe_ok;
    logic          activity;

    assign idle        = (state == ST_IDLE);
    assign timeout_hit = !idle && (tout_count == TW'(TIMEOUT_S));
    assign both_press  = up_p && down_p;
    assign rpt_clear   = mode_p || timeout_hit || both_press;
    assign strobe_ok   = !idle && !mode_p && !timeout_hit;
    assign activity    = mode_p || up_p || down_p || rpt_up || rpt_dn;

    key_autorepeat #(
        .DELAY_TICKS (DELAY_TICKS),
        .PERIOD_TICKS(PERIOD_TICKS)
    ) u_rpt_up (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample_ce(sample_ce),
        .enable   (up_held && !down_held && !idle),
        .clear    (rpt_clear),
        .rpt_pulse(rpt_up)
    );

    key_autorepeat #(
        .DELAY_TICKS (DELAY_TICKS),
        .PERIOD_TICKS(PERIOD_TICKS)
    ) u_rpt_dn (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample_ce(sample_ce),
        .enable   (down_held && !up_held && !idle),
        .clear    (rpt_clear),
        .rpt_pulse(rpt_dn)
    );

    // Field sequencer and page select; timeout wins over a same-cycle mode key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            display_sel <= 1'b0;
        end else if (timeout_hit) begin
            state <= ST_IDLE;
        end else if (mode_p) begin
            case (state)
                ST_IDLE:  begin state <= ST_SEC;   display_sel <= 1'b0; end
                ST_SEC:   begin state <= ST_MIN;   display_sel <= 1'b0; end
                ST_MIN:   begin state <= ST_HOUR;  display_sel <= 1'b0; end
                ST_HOUR:  begin state <= ST_DAY;   display_sel <= 1'b1; end
                ST_DAY:   begin state <= ST_MONTH; display_sel <= 1'b1; end
                ST_MONTH: begin state <= ST_YEAR;  display_sel <= 1'b1; end
                default:  state <= ST_IDLE;
            endcase
        end else if (idle && view_p) begin
            display_sel <= !display_sel;
        end
    end

    // One-clock strobes for the field being edited, from a press or a repeat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_stb <= '0;
            dec_stb <= '0;
        end else begin
            inc_stb <= (strobe_ok && ((up_p && !down_p) || rpt_up)) ? field_onehot(state) : '0;
            dec_stb <= (strobe_ok && ((down_p && !up_p) || rpt_dn)) ? field_onehot(state) : '0;
        end
    end

    // Inactivity counter in seconds; any key activity restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tout_count <= '0;
        end else if (idle || timeout_hit || activity) begin
            tout_count <= '0;
        end else if (tick_1hz) begin
            tout_count <= tout_count + TW'(1);
        end
    end

    assign field      = state;
    assign set_active = !idle;
    assign blank_mask = blink_2hz ? field_onehot(state) : '0;

endmodule
